// File: rtl/call_stack.sv
// Return-address stack: DEPTH x WIDTH registers with circular or saturating full/empty policy.
// Zero-latency top read; push/pop/replace take effect at the edge; strobes always accepted, no backpressure.
module call_stack #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16,
    parameter int WRAP  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           stack_in,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           stack_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam bit CIRC = (WRAP != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp;
    logic [PW-1:0]    top_idx;
    logic [CW-1:0]    cnt;
    logic             ovf_evt;
    logic             unf_evt;

    assign top_idx   = sp - 1'b1;
    assign stack_out = mem[top_idx];
    assign count     = cnt;
    assign empty     = (cnt == '0);
    assign full      = (cnt == CNT_FULL);

    // A push+pop on an empty stack degrades to a plain push, so it can never underflow.
    assign ovf_evt = push && !pop && full;
    assign unf_evt = pop && !push && empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            sp  <= '0;
            cnt <= '0;
        end else if (push && pop && !empty) begin
            mem[top_idx] <= stack_in;
        end else if (push) begin
            if (!full || CIRC) begin
                mem[sp] <= stack_in;
                sp      <= sp + 1'b1;
            end
            if (!full) begin
                cnt <= cnt + 1'b1;
            end
        end else if (pop) begin
            if (!empty || CIRC) begin
                sp <= sp - 1'b1;
            end
            if (!empty) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !clr_err) || ovf_evt;
            underflow <= (underflow && !clr_err) || unf_evt;
        end
    end
endmodule

// File: tb/tb_call_stack.sv
// Directed bench: circular (u_w) and saturating (u_s) stacks, DEPTH=4, WIDTH=11, driven in lockstep.
module tb_call_stack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        clr_err = 1'b0;
    logic [10:0] stack_in = '0;

    logic [10:0] w_out, s_out;
    logic [2:0]  w_cnt, s_cnt;
    logic        w_empty, w_full, w_ovf, w_unf;
    logic        s_empty, s_full, s_ovf, s_unf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    call_stack #(.WIDTH(11), .DEPTH(4), .WRAP(1)) u_w (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .stack_in(stack_in), .clr_err(clr_err),
        .stack_out(w_out), .count(w_cnt), .empty(w_empty), .full(w_full),
        .overflow(w_ovf), .underflow(w_unf)
    );

    call_stack #(.WIDTH(11), .DEPTH(4), .WRAP(0)) u_s (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .stack_in(stack_in), .clr_err(clr_err),
        .stack_out(s_out), .count(s_cnt), .empty(s_empty), .full(s_full),
        .overflow(s_ovf), .underflow(s_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic p, input logic q, input logic [10:0] d, input logic c);
        push = p; pop = q; stack_in = d; clr_err = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    task automatic chk_both(input string tag, input logic [10:0] out, input logic [2:0] cnt);
        chk({tag, "_w_out"}, 32'(w_out), 32'(out));
        chk({tag, "_s_out"}, 32'(s_out), 32'(out));
        chk({tag, "_w_cnt"}, 32'(w_cnt), 32'(cnt));
        chk({tag, "_s_cnt"}, 32'(s_cnt), 32'(cnt));
    endtask

    initial begin
        // Reset state
        #12;
        chk_both("rst", 11'h000, 3'd0);
        chk("rst_empty", 32'({w_empty, s_empty}), 32'b11);
        chk("rst_full", 32'({w_full, s_full}), 32'b00);
        chk("rst_flags", 32'({w_ovf, w_unf, s_ovf, s_unf}), 32'b0000);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic LIFO
        cyc(1, 0, 11'h010, 0);
        cyc(1, 0, 11'h020, 0);
        cyc(1, 0, 11'h030, 0);
        chk_both("lifo_push3", 11'h030, 3'd3);
        chk_both("lifo_pop1", 11'h030, 3'd3);
        cyc(0, 1, 11'h000, 0);
        chk_both("lifo_pop2", 11'h020, 3'd2);
        cyc(0, 1, 11'h000, 0);
        chk_both("lifo_pop3", 11'h010, 3'd1);
        cyc(0, 1, 11'h000, 0);
        chk("lifo_cnt", 32'({w_cnt, s_cnt}), 32'({3'd0, 3'd0}));
        chk("lifo_empty", 32'({w_empty, s_empty}), 32'b11);
        chk("lifo_flags", 32'({w_ovf, w_unf, s_ovf, s_unf}), 32'b0000);

        // Overflow / underflow, circular vs saturating
        pulse_rst();
        cyc(1, 0, 11'h001, 0);
        cyc(1, 0, 11'h002, 0);
        cyc(1, 0, 11'h003, 0);
        chk("ovf_nfull3", 32'({w_full, s_full}), 32'b00);
        cyc(1, 0, 11'h004, 0);
        chk("ovf_full4", 32'({w_full, s_full}), 32'b11);
        chk("ovf_noflag4", 32'({w_ovf, s_ovf}), 32'b00);
        cyc(1, 0, 11'h005, 0);
        chk("ovf_flag", 32'({w_ovf, s_ovf}), 32'b11);
        chk("ovf_cnt", 32'({w_cnt, s_cnt}), 32'({3'd4, 3'd4}));
        chk("ovf_w_top", 32'(w_out), 32'h005);
        chk("ovf_s_top", 32'(s_out), 32'h004);
        cyc(0, 1, 11'h000, 0);
        chk("ovf_w_pop2", 32'(w_out), 32'h004);
        chk("ovf_s_pop2", 32'(s_out), 32'h003);
        cyc(0, 1, 11'h000, 0);
        chk("ovf_w_pop3", 32'(w_out), 32'h003);
        chk("ovf_s_pop3", 32'(s_out), 32'h002);
        cyc(0, 1, 11'h000, 0);
        chk("ovf_w_pop4", 32'(w_out), 32'h002);
        chk("ovf_s_pop4", 32'(s_out), 32'h001);
        cyc(0, 1, 11'h000, 0);
        chk("unf_cnt0", 32'({w_cnt, s_cnt}), 32'({3'd0, 3'd0}));
        chk("unf_noflag", 32'({w_unf, s_unf}), 32'b00);
        chk("unf_w_stale", 32'(w_out), 32'h005);
        chk("unf_s_top", 32'(s_out), 32'h004);
        cyc(0, 1, 11'h000, 0);
        chk("unf_flag", 32'({w_unf, s_unf}), 32'b11);
        chk("unf_cnt", 32'({w_cnt, s_cnt}), 32'({3'd0, 3'd0}));
        chk("unf_w_wrap", 32'(w_out), 32'h004);
        chk("unf_s_hold", 32'(s_out), 32'h004);

        // Replace top
        pulse_rst();
        cyc(1, 0, 11'h100, 0);
        cyc(1, 0, 11'h200, 0);
        cyc(1, 1, 11'h2AA, 0);
        chk_both("rep", 11'h2AA, 3'd2);
        chk("rep_flags", 32'({w_ovf, w_unf, s_ovf, s_unf}), 32'b0000);
        cyc(0, 1, 11'h000, 0);
        chk_both("rep_pop", 11'h100, 3'd1);
        cyc(0, 1, 11'h000, 0);
        chk("rep_empty", 32'({w_empty, s_empty}), 32'b11);
        cyc(1, 1, 11'h055, 0);
        chk_both("rep_empty_pp", 11'h055, 3'd1);
        chk("rep_empty_unf", 32'({w_unf, s_unf}), 32'b00);

        // Sticky flags and clr_err
        cyc(0, 1, 11'h000, 0);
        cyc(0, 1, 11'h000, 0);
        chk("stk_unf_set", 32'({w_unf, s_unf}), 32'b11);
        cyc(0, 0, 11'h000, 0);
        chk("stk_unf_hold", 32'({w_unf, s_unf}), 32'b11);
        cyc(0, 0, 11'h000, 1);
        chk("stk_unf_clr", 32'({w_unf, s_unf}), 32'b00);
        cyc(0, 1, 11'h000, 1);
        chk("stk_set_wins", 32'({w_unf, s_unf}), 32'b11);

        // Async reset between edges
        pulse_rst();
        cyc(1, 0, 11'h001, 0);
        cyc(1, 0, 11'h002, 0);
        cyc(1, 0, 11'h003, 0);
        chk_both("arst_pre", 11'h003, 3'd3);
        #2;
        rst = 1'b1;
        #1;
        chk_both("arst_mid", 11'h000, 3'd0);
        chk("arst_empty", 32'({w_empty, s_empty}), 32'b11);
        chk("arst_flags", 32'({w_ovf, w_unf, s_ovf, s_unf}), 32'b0000);
        #1;
        rst = 1'b0;
        cyc(1, 0, 11'h7FF, 0);
        chk_both("arst_resume", 11'h7FF, 3'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
